oc_dispatch_sched: RTL and testbench

//  Parametrised successor to the fixed 4-collector scheduler. It arbitrates N_OC operand

---
 rtl/sched_pkg.sv | 22 ++
 rtl/oc_dispatch_sched_rr_arbiter.sv | 40 ++++
 rtl/oc_dispatch_sched.sv | 119 +++++++++++
 tb/tb_oc_dispatch_sched.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared definitions for the operand-collector dispatch scheduler.
//   oc_idx_w : index width for a given collector count (at least 1 bit)
//   grant_vec_t : grant vector wide enough for the largest supported N_OC
//   rr_next  : round-robin pointer update (one past the winner, explicit wrap)
package sched_pkg;

  localparam int MAX_OC = 16;

  typedef logic [MAX_OC-1:0] grant_vec_t;

  function automatic int oc_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Holds the pointer when nothing was granted; wraps without relying on
  // power-of-2 overflow so that odd collector counts stay in range.
  function automatic int rr_next(input int ptr, input int k, input bit vld, input int n);
    if (!vld) return ptr;
    return (k + 1 >= n) ? 0 : k + 1;
  endfunction

endpackage

// File: rtl/oc_dispatch_sched_rr_arbiter.sv
// Combinational round-robin pick: the lowest requesting index at or after ptr
// wins, wrapping N-1 -> 0.
//   req     : request vector
//   ptr     : priority start index (always < N)
//   gnt     : one-hot winner, zero when no request
//   gnt_idx : binary index of the winner (0 when none)
//   vld     : at least one request present
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         vld
);

  int  idx;
  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = W'(idx);
      end
    end
  end

  assign vld = |req;

endmodule

// File: rtl/oc_dispatch_sched.sv
// Dispatch scheduler: arbitrates N_OC operand collectors onto one ALU and one
// MEM issue slot per cycle with independent round-robin pointers.
// Optional feature macro: SCHED_PERF_CNT_EN adds saturating perf counters
// (alu_issue_cnt, mem_issue_cnt, wb_stall_cnt).
// Ports:
//   clk, rst              : clock, async active-low reset
//   rdy_oc                : collector holds a ready instruction
//   reg_write_oc          : instruction writes the RF
//   mem_read_oc/write_oc  : instruction is a load/store
//   regwrite_last_mem     : MEM last stage owns the RF write port this cycle
//   mem_rdy               : MEM pipe accepts an issue this cycle
//   alu_grt, mem_grt      : registered one-hot grants
//   alu_rr_ptr/mem_rr_ptr : current priority indices
module oc_dispatch_sched import sched_pkg::*; #(
  parameter int N_OC  = 4,
  parameter int CNT_W = 32,
  localparam int IDX_W = oc_idx_w(N_OC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_OC-1:0]   rdy_oc,
  input  logic [N_OC-1:0]   reg_write_oc,
  input  logic [N_OC-1:0]   mem_read_oc,
  input  logic [N_OC-1:0]   mem_write_oc,
  input  logic              regwrite_last_mem,
  input  logic              mem_rdy,
`ifdef SCHED_PERF_CNT_EN
  output logic [CNT_W-1:0]  alu_issue_cnt,
  output logic [CNT_W-1:0]  mem_issue_cnt,
  output logic [CNT_W-1:0]  wb_stall_cnt,
`endif
  output logic [N_OC-1:0]   alu_grt,
  output logic [N_OC-1:0]   mem_grt,
  output logic [IDX_W-1:0]  alu_rr_ptr,
  output logic [IDX_W-1:0]  mem_rr_ptr
);

  logic [N_OC-1:0]  alu_grt_q, mem_grt_q;
  logic [IDX_W-1:0] alu_ptr_q, mem_ptr_q;
  logic [IDX_W-1:0] alu_ptr_d, mem_ptr_d;

  logic [N_OC-1:0]  is_mem, pend, alu_req, mem_req, alu_pre_wb;
  logic [N_OC-1:0]  alu_gnt, mem_gnt;
  logic [IDX_W-1:0] alu_idx, mem_idx;
  logic             alu_vld, mem_vld, mem_fire;

  always_comb begin
    is_mem     = mem_read_oc | mem_write_oc;
    // Last cycle's grantees may still show rdy while they react to the grant.
    pend       = alu_grt_q | mem_grt_q;
    mem_req    = rdy_oc & is_mem & ~pend;
    alu_pre_wb = rdy_oc & ~is_mem & ~pend;
    alu_req    = alu_pre_wb & ~(reg_write_oc & {N_OC{regwrite_last_mem}});
  end

  rr_arbiter #(.N(N_OC), .W(IDX_W)) u_alu_arb (
    .req     (alu_req),
    .ptr     (alu_ptr_q),
    .gnt     (alu_gnt),
    .gnt_idx (alu_idx),
    .vld     (alu_vld)
  );

  rr_arbiter #(.N(N_OC), .W(IDX_W)) u_mem_arb (
    .req     (mem_req),
    .ptr     (mem_ptr_q),
    .gnt     (mem_gnt),
    .gnt_idx (mem_idx),
    .vld     (mem_vld)
  );

  assign mem_fire  = mem_vld & mem_rdy;
  assign alu_ptr_d = IDX_W'(rr_next(int'(alu_ptr_q), int'(alu_idx), alu_vld, N_OC));
  assign mem_ptr_d = IDX_W'(rr_next(int'(mem_ptr_q), int'(mem_idx), mem_fire, N_OC));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_grt_q <= '0;
      mem_grt_q <= '0;
      alu_ptr_q <= '0;
      mem_ptr_q <= '0;
    end else begin
      alu_grt_q <= alu_gnt;
      mem_grt_q <= mem_fire ? mem_gnt : '0;
      alu_ptr_q <= alu_ptr_d;
      mem_ptr_q <= mem_ptr_d;
    end
  end

`ifdef SCHED_PERF_CNT_EN
  logic [CNT_W-1:0] alu_cnt_q, mem_cnt_q, wb_cnt_q;
  logic             wb_stall;

  // A request blocked only by the write-port conflict: otherwise eligible.
  assign wb_stall = regwrite_last_mem & |(alu_pre_wb & reg_write_oc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_cnt_q <= '0;
      mem_cnt_q <= '0;
      wb_cnt_q  <= '0;
    end else begin
      if (alu_vld  && alu_cnt_q != '1) alu_cnt_q <= alu_cnt_q + 1'b1;
      if (mem_fire && mem_cnt_q != '1) mem_cnt_q <= mem_cnt_q + 1'b1;
      if (wb_stall && wb_cnt_q  != '1) wb_cnt_q  <= wb_cnt_q + 1'b1;
    end
  end

  assign alu_issue_cnt = alu_cnt_q;
  assign mem_issue_cnt = mem_cnt_q;
  assign wb_stall_cnt  = wb_cnt_q;
`endif

  assign alu_grt    = alu_grt_q;
  assign mem_grt    = mem_grt_q;
  assign alu_rr_ptr = alu_ptr_q;
  assign mem_rr_ptr = mem_ptr_q;

endmodule

// File: tb/tb_oc_dispatch_sched.sv
// Bench for oc_dispatch_sched: directed vector table (N_OC=4), asynchronous
// reset sequence, randomized traffic against a behavioural model, and a
// continuous-request rotation on an N_OC=5 instance.
module tb_oc_dispatch_sched;

  logic clk, rst;
  logic [3:0] rdy4, rw4, mr4, mw4;
  logic [4:0] rdy5, rw5, mr5, mw5;
  logic rlm, mrdy;
  logic [3:0] alu4, mem4;
  logic [1:0] ap4, mp4;
  logic [4:0] alu5, mem5;
  logic [2:0] ap5, mp5;
`ifdef SCHED_PERF_CNT_EN
  logic [5:0]  ac4, mc4, wc4;
  logic [15:0] ac5, mc5, wc5;
`endif

  int n_cmp = 0;
  int n_err = 0;

  oc_dispatch_sched #(.N_OC(4), .CNT_W(6)) dut4 (
    .clk(clk), .rst(rst), .rdy_oc(rdy4), .reg_write_oc(rw4),
    .mem_read_oc(mr4), .mem_write_oc(mw4),
    .regwrite_last_mem(rlm), .mem_rdy(mrdy),
`ifdef SCHED_PERF_CNT_EN
    .alu_issue_cnt(ac4), .mem_issue_cnt(mc4), .wb_stall_cnt(wc4),
`endif
    .alu_grt(alu4), .mem_grt(mem4), .alu_rr_ptr(ap4), .mem_rr_ptr(mp4)
  );

  oc_dispatch_sched #(.N_OC(5), .CNT_W(16)) dut5 (
    .clk(clk), .rst(rst), .rdy_oc(rdy5), .reg_write_oc(rw5),
    .mem_read_oc(mr5), .mem_write_oc(mw5),
    .regwrite_last_mem(rlm), .mem_rdy(mrdy),
`ifdef SCHED_PERF_CNT_EN
    .alu_issue_cnt(ac5), .mem_issue_cnt(mc5), .wb_stall_cnt(wc5),
`endif
    .alu_grt(alu5), .mem_grt(mem5), .alu_rr_ptr(ap5), .mem_rr_ptr(mp5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: scan from the pointer with modulo arithmetic.
  typedef struct {
    logic [15:0] alu_g;
    logic [15:0] mem_g;
    int          ap;
    int          mp;
    longint      ac;
    longint      mc;
    longint      wc;
  } mstate_t;

  mstate_t s4, s5, s4n, s5n;

  function automatic mstate_t mreset();
    mstate_t r;
    r.alu_g = '0; r.mem_g = '0; r.ap = 0; r.mp = 0;
    r.ac = 0; r.mc = 0; r.wc = 0;
    return r;
  endfunction

  function automatic mstate_t mstep(mstate_t s, int n, logic [15:0] rdy, logic [15:0] rw,
                                    logic [15:0] mr, logic [15:0] mw, logic l_rlm,
                                    logic l_mrdy, longint cmax);
    mstate_t r = s;
    logic [15:0] pend = s.alu_g | s.mem_g;
    int ak = -1;
    int mk = -1;
    bit stall = 0;
    for (int off = 0; off < n; off++) begin
      int j = (s.ap + off) % n;
      if (ak < 0 && rdy[j] && !(mr[j] || mw[j]) && !pend[j] && !(rw[j] && l_rlm)) ak = j;
    end
    for (int off = 0; off < n; off++) begin
      int j = (s.mp + off) % n;
      if (mk < 0 && rdy[j] && (mr[j] || mw[j]) && !pend[j]) mk = j;
    end
    for (int i = 0; i < n; i++)
      if (rdy[i] && !(mr[i] || mw[i]) && !pend[i] && rw[i] && l_rlm) stall = 1;
    if (!l_mrdy) mk = -1;
    r.alu_g = (ak >= 0) ? (16'h1 << ak) : 16'h0;
    r.mem_g = (mk >= 0) ? (16'h1 << mk) : 16'h0;
    if (ak >= 0) r.ap = (ak + 1) % n;
    if (mk >= 0) r.mp = (mk + 1) % n;
    if (ak >= 0 && r.ac < cmax) r.ac++;
    if (mk >= 0 && r.mc < cmax) r.mc++;
    if (stall && r.wc < cmax) r.wc++;
    return r;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: predict from the current inputs, then compare both DUTs.
  task automatic step();
    s4n = mstep(s4, 4, {12'b0, rdy4}, {12'b0, rw4}, {12'b0, mr4}, {12'b0, mw4}, rlm, mrdy, 63);
    s5n = mstep(s5, 5, {11'b0, rdy5}, {11'b0, rw5}, {11'b0, mr5}, {11'b0, mw5}, rlm, mrdy, 65535);
    @(posedge clk);
    #1;
    s4 = s4n;
    s5 = s5n;
    chk("m4_alu_grt", alu4, s4.alu_g[3:0]);
    chk("m4_mem_grt", mem4, s4.mem_g[3:0]);
    chk("m4_alu_ptr", ap4, s4.ap);
    chk("m4_mem_ptr", mp4, s4.mp);
    chk("m5_alu_grt", alu5, s5.alu_g[4:0]);
    chk("m5_mem_grt", mem5, s5.mem_g[4:0]);
    chk("m5_alu_ptr", ap5, s5.ap);
    chk("m5_mem_ptr", mp5, s5.mp);
`ifdef SCHED_PERF_CNT_EN
    chk("m4_alu_cnt", ac4, s4.ac);
    chk("m4_mem_cnt", mc4, s4.mc);
    chk("m4_wb_cnt", wc4, s4.wc);
    chk("m5_alu_cnt", ac5, s5.ac);
`endif
  endtask

  typedef struct {
    logic [3:0] rdy, rw, mr;
    logic       l_rlm, l_mrdy;
    logic [3:0] ea, em;
    logic [1:0] eap, emp;
  } vec_t;

  vec_t tv[21];

  int gcount, wraps, prev_ap, k;
  int last_g[5];

  initial begin
    // rdy, rw, mr, rlm, mrdy, exp alu, exp mem, exp aptr, exp mptr
    tv[0]  = '{4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0000, 2'd1, 2'd0};
    tv[1]  = '{4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0010, 4'b0000, 2'd2, 2'd0};
    tv[2]  = '{4'b1110, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0000, 2'd3, 2'd0};
    tv[3]  = '{4'b1100, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1000, 4'b0000, 2'd0, 2'd0};
    tv[4]  = '{4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 2'd0};
    tv[5]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 2'd0};
    tv[6]  = '{4'b1010, 4'b0000, 4'b1010, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 2'd0};
    tv[7]  = '{4'b1010, 4'b0000, 4'b1010, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 2'd0};
    tv[8]  = '{4'b1010, 4'b0000, 4'b1010, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 2'd0};
    tv[9]  = '{4'b1010, 4'b0000, 4'b1010, 1'b0, 1'b1, 4'b0000, 4'b0010, 2'd0, 2'd2};
    tv[10] = '{4'b1010, 4'b0000, 4'b1010, 1'b0, 1'b1, 4'b0000, 4'b1000, 2'd0, 2'd0};
    tv[11] = '{4'b1000, 4'b0000, 4'b1010, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 2'd0};
    tv[12] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 2'd0};
    tv[13] = '{4'b0101, 4'b0100, 4'b0000, 1'b1, 1'b0, 4'b0001, 4'b0000, 2'd1, 2'd0};
    tv[14] = '{4'b0101, 4'b0100, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 2'd1, 2'd0};
    tv[15] = '{4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0000, 2'd3, 2'd0};
    tv[16] = '{4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd3, 2'd0};
    tv[17] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd3, 2'd0};
    tv[18] = '{4'b0011, 4'b0000, 4'b0001, 1'b0, 1'b1, 4'b0010, 4'b0001, 2'd2, 2'd1};
    tv[19] = '{4'b0011, 4'b0000, 4'b0001, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'd2, 2'd1};
    tv[20] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd2, 2'd1};

    rst = 1'b0;
    rdy4 = '0; rw4 = '0; mr4 = '0; mw4 = '0;
    rdy5 = '0; rw5 = '0; mr5 = '0; mw5 = '0;
    rlm = 1'b0; mrdy = 1'b0;
    s4 = mreset();
    s5 = mreset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alu_grt", alu4, 0);
    chk("rst_mem_grt", mem4, 0);
    chk("rst_alu_ptr", ap4, 0);
    chk("rst_mem_ptr", mp4, 0);
    @(negedge clk);
    rst = 1'b1;

    // Directed table: rotation, MEM handshake, write-port masking, mixed issue.
    for (int i = 0; i < 21; i++) begin
      rdy4 = tv[i].rdy; rw4 = tv[i].rw; mr4 = tv[i].mr; mw4 = '0;
      rlm = tv[i].l_rlm; mrdy = tv[i].l_mrdy;
      step();
      chk($sformatf("tv%0d_alu_grt", i), alu4, tv[i].ea);
      chk($sformatf("tv%0d_mem_grt", i), mem4, tv[i].em);
      chk($sformatf("tv%0d_alu_ptr", i), ap4, tv[i].eap);
      chk($sformatf("tv%0d_mem_ptr", i), mp4, tv[i].emp);
    end

    // Reset asserted while a grant is visible clears it without a clock edge.
    rdy4 = 4'b0100; rw4 = '0; mr4 = '0; rlm = 1'b0; mrdy = 1'b0;
    step();
    chk("t5_pre_alu_grt", alu4, 4'b0100);
    chk("t5_pre_alu_ptr", ap4, 3);
    #1;
    rst = 1'b0;
    #1;
    chk("t5_async_alu_grt", alu4, 0);
    chk("t5_async_alu_ptr", ap4, 0);
    chk("t5_async_mem_ptr", mp4, 1'b0);
    s4 = mreset();
    s5 = mreset();
    rdy4 = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
    rdy4 = 4'b0010;
    step();
    chk("t5_post_alu_grt", alu4, 4'b0010);
    chk("t5_post_alu_ptr", ap4, 2);
    rdy4 = '0;
    step();

    // Randomized traffic on the 4-collector instance.
    for (int c = 0; c < 400; c++) begin
      rdy4 = 4'($urandom);
      rw4  = 4'($urandom);
      mr4  = 4'($urandom) & 4'($urandom);
      mw4  = 4'($urandom) & 4'($urandom);
      rlm  = 1'($urandom_range(0, 1));
      mrdy = 1'($urandom_range(0, 3) != 0);
      step();
    end
    rdy4 = '0; rw4 = '0; mr4 = '0; mw4 = '0; rlm = 1'b0; mrdy = 1'b0;
    step();
    step();

    // Five collectors requesting ALU continuously.
    gcount = 0;
    wraps = 0;
    for (int i = 0; i < 5; i++) last_g[i] = -1;
    prev_ap = int'(ap5);
    rdy5 = 5'b11111;
    for (int c = 0; c < 30; c++) begin
      step();
      k = -1;
      for (int i = 0; i < 5; i++) if (alu5[i]) k = i;
      if (k >= 0) begin
        if (last_g[k] >= 0) chk($sformatf("t6_starve_oc%0d", k), (gcount - last_g[k]) <= 5, 1);
        last_g[k] = gcount;
        gcount++;
      end
      if (prev_ap == 4 && ap5 == 3'd0) wraps++;
      prev_ap = int'(ap5);
    end
    chk("t6_grant_count", gcount, 30);
    chk("t6_wraps", wraps, 6);
`ifdef SCHED_PERF_CNT_EN
    chk("t6_alu_issue_cnt", ac5, gcount);
`endif
    rdy5 = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
